// File: rtl/rv32_fetch_pkg.sv
// rtl/rv32_fetch_pkg.sv - shared types and constants for the RV32 fetch stage
package rv32_fetch_pkg;

  // Canonical RV32 NOP (addi x0, x0, 0), presented to decode when nothing is valid
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One fetched instruction together with the byte PC it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Fetch control states; HALT is only reachable with misaligned-redirect checking
  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetch entries with flush and async reset
module fetch_queue
  import rv32_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  // A pop frees the slot a same-cycle push needs, so push at full is legal with a pop
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; flush discards everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW + 1)'(1);
        2'b01:   count_d = count_q - (PW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until the occupancy says otherwise
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV32 fetch stage; FETCH_MISALIGN_CHECK_EN enables misaligned-redirect halt
module instruction_fetch
  import rv32_fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 5,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [31:0]           if_instr,
  output logic [31:0]           if_pc,
  output logic                  misaligned_err
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_pc;
  logic         fetch_en;
  logic         redirect_takes_pc;
  logic         q_push, q_pop, q_full, q_empty;
  fetch_entry_t q_wr, q_rd;

  // Word-align the target; the low bits only matter to the misalignment check
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHECK_EN
  fetch_state_e state_q, state_d;
  logic         err_q, err_d;
  logic         redirect_aligned;

  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  // Fetch state and sticky misalignment flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Misaligned redirect halts fetch; only an aligned redirect resumes it
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (redirect_valid) begin
      if (redirect_aligned) begin
        state_d = FETCH;
        err_d   = 1'b0;
      end else begin
        state_d = HALT;
        err_d   = 1'b1;
      end
    end
  end

  assign fetch_en          = (state_q == FETCH);
  assign misaligned_err    = err_q;
  assign redirect_takes_pc = redirect_valid && redirect_aligned;
`else
  assign fetch_en          = 1'b1;
  assign misaligned_err    = 1'b0;
  assign redirect_takes_pc = redirect_valid;
`endif

  assign imem_addr = pc_q[ADDR_WIDTH+1:2];

  // A redirect cycle neither hands anything to decode nor captures anything
  assign if_valid = !q_empty && !redirect_valid;
  assign q_pop    = if_valid && if_ready;
  assign q_push   = !redirect_valid && fetch_en && (!q_full || q_pop);
  assign q_wr     = '{pc: pc_q, instr: imem_rdata};

  assign if_instr = if_valid ? q_rd.instr : NOP_INSTR;
  assign if_pc    = if_valid ? q_rd.pc    : 32'h0000_0000;

  // Next PC: redirect wins, otherwise advance one word per captured instruction
  always_comb begin
    pc_d = pc_q;
    if (redirect_takes_pc) begin
      pc_d = target_pc;
    end else if (q_push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Program counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk    (clk),
    .rst    (rst),
    .push   (q_push),
    .pop    (q_pop),
    .flush  (redirect_valid),
    .wr_data(q_wr),
    .rd_data(q_rd),
    .full   (q_full),
    .empty  (q_empty)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;
  import rv32_fetch_pkg::*;

  localparam int          AW  = 5;
  localparam int          MEM_WORDS = 32;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic          misaligned_err;

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   prog [3];

  int vectors = 0;
  int miscompares = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  gen_pc;
  bit           halted;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  instruction_fetch #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (RPC),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .misaligned_err(misaligned_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image seen at a byte PC: word index wraps modulo the memory size
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 2) % MEM_WORDS);
    return mem[idx];
  endfunction

  // Expected instruction stream restarts at pc; everything older is discarded
  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = pc;
    halted = 1'b0;
  endtask

  task automatic sb_halt();
    exp_q.delete();
    halted = 1'b1;
  endtask

  // Monitor: compare every decode handshake against the expected stream
  initial begin : monitor
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    bit          prev_stall;
    fetch_entry_t e;
    prev_stall = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (redirect_valid) check("valid_in_redirect", {31'b0, if_valid}, 32'd0);
        if (!if_valid) begin
          check("idle_instr", if_instr, NOP_INSTR);
          check("idle_pc", if_pc, 32'd0);
        end else if (prev_stall) begin
          check("hold_pc", if_pc, prev_pc);
          check("hold_instr", if_instr, prev_instr);
        end
        if (if_valid && if_ready) begin
          if (!halted) begin
            while (exp_q.size() < 4) begin
              exp_q.push_back('{pc: gen_pc, instr: mem_word(gen_pc)});
              gen_pc = gen_pc + 32'd4;
            end
          end
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_unexpected: got pc %h while none expected", if_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", if_pc, e.pc);
            check("sb_instr", if_instr, e.instr);
          end
        end
        prev_stall = if_valid && !if_ready;
        prev_pc = if_pc;
        prev_instr = if_instr;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] t;
    logic [31:0] halt_addr;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    prog[0] = 32'he3600093;
    prog[1] = 32'h2a600113;
    prog[2] = 32'h021141b3;
    for (int i = 0; i < 3; i++) mem[i] = prog[i];

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b0;
    sb_restart(RPC);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_addr", {27'b0, imem_addr}, 32'd0);
    check("rst_err", {31'b0, misaligned_err}, 32'd0);
    check("rst_instr", if_instr, NOP_INSTR);
    check("rst_pc", if_pc, 32'd0);

    // Free-running after release
    @(posedge clk); #1;
    rst = 1'b0;
    if_ready = 1'b1;
    @(negedge clk);
    check("first_valid", {31'b0, if_valid}, 32'd0);
    check("first_addr", {27'b0, imem_addr}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("run_valid", {31'b0, if_valid}, 32'd1);
      check("run_pc", if_pc, 32'(4 * k));
      check("run_instr", if_instr, prog[k]);
    end

    // Fill the queue, then redirect to 0x14
    @(posedge clk); #1;
    if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h14;
    if_ready = 1'b1;
    sb_restart(32'h14);
    @(negedge clk);
    check("redir_n_valid", {31'b0, if_valid}, 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_n1_valid", {31'b0, if_valid}, 32'd0);
    check("redir_n1_addr", {27'b0, imem_addr}, 32'd5);
    @(negedge clk);
    check("redir_n2_valid", {31'b0, if_valid}, 32'd1);
    check("redir_n2_pc", if_pc, 32'h14);
    check("redir_n2_instr", if_instr, mem[5]);

    // Wrap of the word address
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h7C;
    sb_restart(32'h7C);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_addr31", {27'b0, imem_addr}, 32'd31);
    @(negedge clk);
    check("wrap_pc7c", if_pc, 32'h7C);
    check("wrap_addr0", {27'b0, imem_addr}, 32'd0);
    @(negedge clk);
    check("wrap_pc80", if_pc, 32'h80);
    check("wrap_instr80", if_instr, mem[0]);

    // Asynchronous reset with a full queue
    @(posedge clk); #1;
    if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_valid", {31'b0, if_valid}, 32'd1);
    rst = 1'b1;
    sb_restart(RPC);
    #1;
    check("async_rst_valid", {31'b0, if_valid}, 32'd0);
    check("async_rst_addr", {27'b0, imem_addr}, 32'(RPC >> 2));

    // Backpressure from reset: queue fills, fetch stalls at word 2
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    if_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("bp_valid", {31'b0, if_valid}, 32'd1);
    check("bp_addr", {27'b0, imem_addr}, 32'd2);
    check("bp_instr", if_instr, prog[0]);
    check("bp_pc", if_pc, 32'd0);
    @(posedge clk); #1;
    if_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        t = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
        t[1:0] = 2'b00;
`endif
        redirect_valid = 1'b1;
        redirect_pc = t;
        sb_restart(t & 32'hFFFF_FFFC);
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    repeat (3) @(negedge clk);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect halts fetch, aligned redirect resumes
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    sb_halt();
    @(negedge clk);
    halt_addr = {27'b0, imem_addr};
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mis_err", {31'b0, misaligned_err}, 32'd1);
      check("mis_valid", {31'b0, if_valid}, 32'd0);
      check("mis_addr_held", {27'b0, imem_addr}, halt_addr);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    sb_restart(32'h10);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("resume_err", {31'b0, misaligned_err}, 32'd0);
    check("resume_addr", {27'b0, imem_addr}, 32'd4);
    @(negedge clk);
    check("resume_pc", if_pc, 32'h10);
`else
    // Misaligned target is truncated to a word, no error flag
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    sb_restart(32'h20);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("trunc_err", {31'b0, misaligned_err}, 32'd0);
    check("trunc_addr", {27'b0, imem_addr}, 32'd8);
    @(negedge clk);
    check("trunc_pc", if_pc, 32'h20);
    halt_addr = '0;
`endif
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
